// File: rtl/sync_memory.sv
// sync_memory: word-addressed single-port RAM behind a read/write/ready handshake,
// with programmable access latency and an out-of-range error flag.
`default_nettype none

module sync_memory #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_value,
  output logic [DATA_WIDTH-1:0] read_value,
  output logic                  ready,
  output logic                  error,
  output logic                  busy
);

  localparam int                  IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    op_read;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wait_cnt;
  logic                    in_range;
  logic [IDX_WIDTH-1:0]    idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign idx      = addr_q[IDX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (read || write) begin
          if (LATENCY > 0) state_next = WAIT;
          else             state_next = ACCESS;
        end
      end
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_read    <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= 4'd0;
      read_value <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (read || write) begin
            // Read takes priority; a simultaneous write is dropped.
            op_read  <= read;
            op_write <= write && !read;
            addr_q   <= address;
            wdata_q  <= write_value;
            wait_cnt <= 4'd0;
            busy     <= 1'b1;
          end
        end
        WAIT: wait_cnt <= wait_cnt + 4'd1;
        ACCESS: begin
          ready <= 1'b1;
          error <= !in_range;
          busy  <= 1'b0;
          if (!in_range)    read_value <= '0;
          else if (op_read) read_value <= mem[idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state == ACCESS) && op_write && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_memory.sv
// tb_sync_memory: three sync_memory instances (LATENCY 0, 3, 4) checked against an array model.
`default_nettype none

module tb_sync_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  wv = '0;
  int          sel = 0;
  logic [2:0]  kill = 3'b000;

  logic [2:0]  rd_g, wr_g, rstn_g, rdy, err, bsy;
  logic [7:0]  rv [3];

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;

  logic [7:0]  mdl [3][128];
  bit          known [3][128];
  logic [7:0]  last_rv [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rd_g[g]   = rd && (sel == g);
    assign wr_g[g]   = wr && (sel == g);
    assign rstn_g[g] = rst_n && !kill[g];
    sync_memory #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(128),
      .LATENCY((g == 0) ? 0 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk(clk), .rst_n(rstn_g[g]), .read(rd_g[g]), .write(wr_g[g]),
      .address(address), .write_value(wv),
      .read_value(rv[g]), .ready(rdy[g]), .error(err[g]), .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One full transaction on instance k with latency, busy, error and data checks.
  task automatic txn(input int k, input bit r, input bit w, input int a, input logic [7:0] v);
    int         lat = lat_of(k);
    bit         inr = (a < 128);
    bit         rv_known;
    logic [7:0] exp_rv;
    int         cnt = 0;
    int         busy_n = 0;
    bit         seen = 0;
    string      t = $sformatf("d%0d_%s%s@%0d", k, r ? "r" : "", w ? "w" : "", a);
    rv_known = 1'b1;
    if (!inr)         exp_rv = 8'h00;
    else if (r)       begin exp_rv = mdl[k][a]; rv_known = known[k][a]; end
    else              exp_rv = last_rv[k];
    @(negedge clk);
    sel = k; address = 16'(a); wv = v; rd = r; wr = w;
    while (!seen && cnt < 40) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        address = 16'($urandom_range(0, 65535)); wv = 8'($urandom);
      end
      if (rdy[k]) seen = 1'b1;
      else if (bsy[k]) busy_n++;
    end
    rd = 1'b0; wr = 1'b0;
    chk({t, "_ready_seen"}, 32'(seen), 32'd1);
    chk({t, "_latency"}, 32'(cnt), 32'(lat + 2));
    chk({t, "_busy_cycles"}, 32'(busy_n), 32'(lat + 1));
    chk({t, "_busy_at_ready"}, 32'(bsy[k]), 32'd0);
    chk({t, "_error"}, 32'(err[k]), 32'(!inr));
    if (rv_known) chk({t, "_read_value"}, 32'(rv[k]), 32'(exp_rv));
    if (!r && w && inr) begin mdl[k][a] = v; known[k][a] = 1'b1; end
    last_rv[k] = rv_known ? exp_rv : rv[k];
    @(posedge clk); @(negedge clk);
    chk({t, "_ready_pulse_end"}, {30'd0, rdy[k], err[k]}, 32'd0);
  endtask

  initial begin
    int          cnt;
    int          t_prev;
    int          addrs [3];
    bit          seen;
    bit          any_ready;

    for (int k = 0; k < 3; k++) begin
      last_rv[k] = 8'h00;
      for (int a = 0; a < 128; a++) known[k][a] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_d%0d_outputs", k), {rv[k], rdy[k], err[k], bsy[k]}, 32'd0);
    end
    rst_n = 1'b1;

    // Basic write/read at zero latency.
    txn(0, 0, 1, 3, 8'hA5);
    txn(0, 1, 0, 3, 8'h00);

    // Latency 3 read.
    txn(1, 0, 1, 0, 8'h6E);
    txn(1, 1, 0, 0, 8'h00);

    // Simultaneous read and write: read wins.
    txn(0, 0, 1, 5, 8'h22);
    txn(0, 1, 1, 5, 8'h11);
    txn(0, 1, 0, 5, 8'h00);

    // Out-of-range write must not alias onto 200 % 128.
    txn(0, 0, 1, 72, 8'h5A);
    txn(0, 0, 1, 200, 8'hFF);
    txn(0, 1, 0, 72, 8'h00);
    txn(0, 1, 0, 70000 % 65536, 8'h00);

    // Back-to-back reads with read held high.
    addrs[0] = 3; addrs[1] = 5; addrs[2] = 72;
    @(negedge clk);
    sel = 0; rd = 1'b1; wr = 1'b0; address = 16'(addrs[0]);
    t_prev = 0;
    for (int p = 0; p < 3; p++) begin
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 40) begin
        @(posedge clk); cnt++;
        @(negedge clk);
        seen = rdy[0];
      end
      chk($sformatf("b2b_%0d_seen", p), 32'(seen), 32'd1);
      chk($sformatf("b2b_%0d_value", p), 32'(rv[0]), 32'(mdl[0][addrs[p]]));
      if (p == 0) chk("b2b_0_latency", 32'(cnt), 32'd2);
      else        chk($sformatf("b2b_%0d_period", p), 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      last_rv[0] = mdl[0][addrs[p]];
      if (p < 2) address = 16'(addrs[p + 1]);
      else       rd = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk("b2b_after_ready", 32'(rdy[0]), 32'd0);

    // Reset during WAIT aborts the write.
    txn(2, 0, 1, 7, 8'h3C);
    @(negedge clk);
    sel = 2; address = 16'd7; wv = 8'hC3; wr = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort_busy_in_wait", 32'(bsy[2]), 32'd1);
    kill[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_busy_after_reset", 32'(bsy[2]), 32'd0);
    chk("abort_rv_after_reset", 32'(rv[2]), 32'd0);
    kill[2] = 1'b0; wr = 1'b0;
    any_ready = 1'b0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (rdy[2]) any_ready = 1'b1;
    end
    chk("abort_no_ready", 32'(any_ready), 32'd0);
    last_rv[2] = 8'h00;
    txn(2, 1, 0, 7, 8'h00);

    // Randomized mix against the model.
    for (int i = 0; i < 45; i++) begin
      int k = $urandom_range(0, 2);
      int p = $urandom_range(0, 9);
      int a = $urandom_range(0, 127);
      logic [7:0] v = 8'($urandom);
      if (p <= 3)                   txn(k, 0, 1, a, v);
      else if (p <= 6 && known[k][a]) txn(k, 1, 0, a, v);
      else if (p <= 6)              txn(k, 0, 1, a, v);
      else if (p == 7)              txn(k, 1, 0, $urandom_range(128, 65535), v);
      else if (p == 8)              txn(k, 0, 1, $urandom_range(128, 65535), v);
      else                          txn(k, 1, 1, a, v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
